// File: rtl/floppy_pkg.sv
// Shared types and constants for the floppy step/direction seek controller.
package floppy_pkg;

  localparam int unsigned TRACK_W   = 7;
  localparam int unsigned MAX_TRACK = 79;

  localparam logic DIR_IN  = 1'b1;
  localparam logic DIR_OUT = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StDirSetup,
    StStepHi,
    StStepLo,
    StSettle
  } seek_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/floppy_step_timer.sv
// Loadable down-counter with a zero flag; times every interval of the seek sequence.
module floppy_step_timer
  import floppy_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/floppy_seek_ctrl.sv
// Drives dir_sel/step to move the floppy head to a commanded track, recalibrates via t00_sens,
// and keeps the current head position.
module floppy_seek_ctrl
  import floppy_pkg::*;
#(
  parameter int unsigned STEP_PULSE_CYC = 4,
  parameter int unsigned STEP_RATE_CYC  = 20,
  parameter int unsigned DIR_SETUP_CYC  = 2,
  parameter int unsigned SETTLE_CYC     = 10,
  parameter int unsigned MAX_RECAL      = 85
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic               i_cmd_recal,
  input  logic [TRACK_W-1:0] i_cmd_track,
  output logic               o_dir_sel,
  output logic               o_step,
  input  logic               i_t00_sens,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error,
  output logic [TRACK_W-1:0] o_cur_track,
  output logic               o_track_valid
);

  localparam int unsigned MaxCyc = max_u(max_u(STEP_PULSE_CYC, STEP_RATE_CYC),
                                         max_u(DIR_SETUP_CYC, SETTLE_CYC));
  localparam int unsigned CNT_W  = $clog2(MaxCyc + 1);
  localparam int unsigned RCL_W  = $clog2(MAX_RECAL + 1);

  // Timer loads are N-1 because the zero cycle itself is the last cycle of the interval.
  localparam logic [CNT_W-1:0]   LdSetup  = CNT_W'(DIR_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0]   LdHi     = CNT_W'(STEP_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   LdLo     = CNT_W'(STEP_RATE_CYC - STEP_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]   LdSettle = CNT_W'(SETTLE_CYC - 1);
  localparam logic [TRACK_W-1:0] MaxTrkV  = TRACK_W'(MAX_TRACK);
  localparam logic [RCL_W-1:0]   MaxRclV  = RCL_W'(MAX_RECAL);

  seek_state_e        r_state, w_state_d;
  logic               r_t00_meta, r_t00_s;
  logic               r_dir, w_dir_d;
  logic               r_step;
  logic               r_busy, w_busy_d;
  logic               r_done, w_done_d;
  logic               r_error, w_error_d;
  logic [TRACK_W-1:0] r_cur, w_cur_d;
  logic               r_valid, w_valid_d;
  logic               r_recal, w_recal_d;
  logic [TRACK_W-1:0] r_remaining, w_rem_d;
  logic [RCL_W-1:0]   r_rcl_cnt, w_rcl_d;
  logic               w_tmr_load;
  logic [CNT_W-1:0]   w_tmr_val;
  logic               w_tmr_zero;
  logic               w_go_step;
  logic               w_go_settle;

  floppy_step_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    w_state_d   = r_state;
    w_dir_d     = r_dir;
    w_busy_d    = r_busy;
    w_done_d    = 1'b0;
    w_error_d   = 1'b0;
    w_cur_d     = r_cur;
    w_valid_d   = r_valid;
    w_recal_d   = r_recal;
    w_rem_d     = r_remaining;
    w_rcl_d     = r_rcl_cnt;
    w_tmr_load  = 1'b0;
    w_tmr_val   = '0;
    w_go_step   = 1'b0;
    w_go_settle = 1'b0;

    case (r_state)
      StIdle: begin
        if (i_cmd_valid) begin
          if (i_cmd_recal) begin
            w_dir_d    = DIR_OUT;
            w_recal_d  = 1'b1;
            w_rcl_d    = '0;
            w_busy_d   = 1'b1;
            w_state_d  = StDirSetup;
            w_tmr_load = 1'b1;
            w_tmr_val  = LdSetup;
          end else if (!r_valid || (i_cmd_track > MaxTrkV)) begin
            w_error_d = 1'b1;
          end else if (i_cmd_track == r_cur) begin
            w_done_d = 1'b1;
          end else begin
            w_recal_d  = 1'b0;
            w_busy_d   = 1'b1;
            w_state_d  = StDirSetup;
            w_tmr_load = 1'b1;
            w_tmr_val  = LdSetup;
            if (i_cmd_track > r_cur) begin
              w_dir_d = DIR_IN;
              w_rem_d = i_cmd_track - r_cur;
            end else begin
              w_dir_d = DIR_OUT;
              w_rem_d = r_cur - i_cmd_track;
            end
          end
        end
      end
      StDirSetup: begin
        if (w_tmr_zero) begin
          if (r_recal && r_t00_s) begin
            w_cur_d     = '0;
            w_valid_d   = 1'b1;
            w_go_settle = 1'b1;
          end else begin
            w_go_step = 1'b1;
          end
        end
      end
      StStepHi: begin
        if (w_tmr_zero) begin
          w_state_d  = StStepLo;
          w_tmr_load = 1'b1;
          w_tmr_val  = LdLo;
        end
      end
      StStepLo: begin
        if (w_tmr_zero) begin
          if (!r_recal) begin
            if (r_remaining != '0) begin
              w_go_step = 1'b1;
            end else if ((r_dir == DIR_OUT) && (r_cur == '0) && !r_t00_s) begin
              // Arrived at logical track 0 but the drive disagrees: position is untrustworthy.
              w_error_d = 1'b1;
              w_valid_d = 1'b0;
              w_busy_d  = 1'b0;
              w_state_d = StIdle;
            end else begin
              w_go_settle = 1'b1;
            end
          end else if (r_t00_s) begin
            w_cur_d     = '0;
            w_valid_d   = 1'b1;
            w_go_settle = 1'b1;
          end else if (r_rcl_cnt == MaxRclV) begin
            w_error_d = 1'b1;
            w_valid_d = 1'b0;
            w_busy_d  = 1'b0;
            w_state_d = StIdle;
          end else begin
            w_go_step = 1'b1;
          end
        end
      end
      StSettle: begin
        if (w_tmr_zero) begin
          w_done_d  = 1'b1;
          w_busy_d  = 1'b0;
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    if (w_go_step) begin
      w_state_d  = StStepHi;
      w_tmr_load = 1'b1;
      w_tmr_val  = LdHi;
      if (r_recal) begin
        w_rcl_d = r_rcl_cnt + RCL_W'(1);
      end else begin
        w_rem_d = r_remaining - TRACK_W'(1);
        w_cur_d = (r_dir == DIR_IN) ? (r_cur + TRACK_W'(1)) : (r_cur - TRACK_W'(1));
      end
    end

    if (w_go_settle) begin
      w_state_d  = StSettle;
      w_tmr_load = 1'b1;
      w_tmr_val  = LdSettle;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_t00_meta  <= 1'b0;
      r_t00_s     <= 1'b0;
      r_dir       <= DIR_OUT;
      r_step      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_cur       <= '0;
      r_valid     <= 1'b0;
      r_recal     <= 1'b0;
      r_remaining <= '0;
      r_rcl_cnt   <= '0;
    end else begin
      r_state     <= w_state_d;
      r_t00_meta  <= i_t00_sens;
      r_t00_s     <= r_t00_meta;
      r_dir       <= w_dir_d;
      // Registered so the drive pin is a clean flop output rather than a state decode.
      r_step      <= (w_state_d == StStepHi);
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_error     <= w_error_d;
      r_cur       <= w_cur_d;
      r_valid     <= w_valid_d;
      r_recal     <= w_recal_d;
      r_remaining <= w_rem_d;
      r_rcl_cnt   <= w_rcl_d;
    end
  end

  assign o_cmd_ready   = (r_state == StIdle);
  assign o_dir_sel     = r_dir;
  assign o_step        = r_step;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;
  assign o_cur_track   = r_cur;
  assign o_track_valid = r_valid;

endmodule

// File: tb/tb_floppy_seek_ctrl.sv
// Self-checking bench for floppy_seek_ctrl: command vector table, a simple drive/head model
// behind t00_sens, and a scoreboard of expected completions.
module tb_floppy_seek_ctrl;

  localparam int PULSE   = 4;
  localparam int RATE    = 20;
  localparam int DSETUP  = 2;
  localparam int SETTLE  = 10;
  localparam int LAT_IMM = 1;
  localparam int LAT_DN  = RATE + SETTLE;
  localparam int LAT_ER  = RATE;
  localparam int LAT_AT0 = DSETUP + SETTLE + 1;

  typedef struct {
    bit recal;
    int track;
    bit stuck;
    bit exp_done;
    int exp_steps;
    bit exp_dir;
    int exp_cur;    // negative: position is don't-care
    bit exp_valid;
    int exp_lat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_recal;
  logic [6:0] cmd_track;
  logic       dir_sel, step, t00_sens, busy, done, error, track_valid;
  logic [6:0] cur_track;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur_id   = -1;
  int   ncyc     = 0;
  int   acc_n    = 0;
  int   n_steps  = 0;
  int   prev_rise = -1;
  int   last_rise = 0;
  int   hi_cnt   = 0;
  bit   in_hi    = 1'b0;
  bit   dir_mix  = 1'b0;
  logic dir_last = 1'b0;
  logic step_q   = 1'b0;
  logic dir_q    = 1'b0;
  int   head_pos = 3;
  bit   stuck    = 1'b0;
  vec_t sb[$];
  vec_t vecs[14];

  assign t00_sens = !stuck && (head_pos == 0);

  always #5 clk = ~clk;

  floppy_seek_ctrl dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_recal   (cmd_recal),
    .i_cmd_track   (cmd_track),
    .o_dir_sel     (dir_sel),
    .o_step        (step),
    .i_t00_sens    (t00_sens),
    .o_busy        (busy),
    .o_done        (done),
    .o_error       (error),
    .o_cur_track   (cur_track),
    .o_track_valid (track_valid)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (cmd %0d): got %0d, expected %0d", name, cur_id, act, exp);
    end
  endtask

  function automatic vec_t mk(bit recal, int track, bit stk, bit dn, int steps, bit dir,
                              int cur, bit valid, int lat);
    vec_t v;
    v.recal = recal; v.track = track; v.stuck = stk; v.exp_done = dn; v.exp_steps = steps;
    v.exp_dir = dir; v.exp_cur = cur; v.exp_valid = valid; v.exp_lat = lat;
    return v;
  endfunction

  // Drive-side monitor: head model, pulse-shape protocol checks and scoreboard pops.
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (rst_n !== 1'b1) begin
      in_hi     = 1'b0;
      hi_cnt    = 0;
      prev_rise = -1;
    end else begin
      if (step && !step_q) begin
        n_steps = n_steps + 1;
        if (dir_sel) head_pos = head_pos + 1;
        else if (head_pos > 0) head_pos = head_pos - 1;
        if (n_steps == 1) chk("first_step_delay", ncyc - acc_n, DSETUP + 1);
        if (prev_rise >= 0) chk("step_period", ncyc - prev_rise, RATE);
        if (n_steps > 1 && dir_sel != dir_last) dir_mix = 1'b1;
        dir_last  = dir_sel;
        prev_rise = ncyc;
        last_rise = ncyc;
        in_hi     = 1'b1;
        hi_cnt    = 0;
      end
      if (step && step_q) chk("dir_hold_while_step", int'(dir_sel), int'(dir_q));
      if (in_hi) begin
        if (step) hi_cnt = hi_cnt + 1;
        else begin
          chk("step_width", hi_cnt, PULSE);
          in_hi = 1'b0;
        end
      end
      if (done || error) begin
        if (sb.size() == 0) begin
          chk("spurious_result", int'({done, error}), 0);
        end else begin
          vec_t e;
          e = sb.pop_front();
          chk("done", int'(done), int'(e.exp_done));
          chk("error", int'(error), int'(!e.exp_done));
          chk("steps", n_steps, e.exp_steps);
          if (n_steps > 0) chk("dir_sel", int'(dir_last), int'(e.exp_dir));
          chk("dir_mixed", int'(dir_mix), 0);
          chk("track_valid", int'(track_valid), int'(e.exp_valid));
          if (e.exp_cur >= 0) chk("cur_track", int'(cur_track), e.exp_cur);
          chk("busy_at_end", int'(busy), 0);
          chk("latency", ncyc - ((n_steps > 0) ? last_rise : acc_n), e.exp_lat);
        end
      end
    end
    step_q = step;
    dir_q  = dir_sel;
  end

  task automatic issue(input bit recal, input int track);
    @(negedge clk);
    cmd_recal = recal;
    cmd_track = 7'(track);
    cmd_valid = 1'b1;
    @(posedge clk);
    acc_n     = ncyc;
    n_steps   = 0;
    prev_rise = -1;
    dir_mix   = 1'b0;
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_result();
    for (int i = 0; i < 4000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("timeout_pending", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic run_vec(input vec_t v);
    stuck = v.stuck;
    repeat (3) @(negedge clk);
    sb.push_back(v);
    issue(v.recal, v.track);
    wait_result();
  endtask

  initial begin
    // recal, track, stuck, done, steps, dir, cur, valid, latency
    vecs[0]  = mk(0, 5,  0, 0, 0,  0, 0,  0, LAT_IMM);
    vecs[1]  = mk(1, 0,  0, 1, 3,  0, 0,  1, LAT_DN);
    vecs[2]  = mk(0, 5,  0, 1, 5,  1, 5,  1, LAT_DN);
    vecs[3]  = mk(0, 2,  0, 1, 3,  0, 2,  1, LAT_DN);
    vecs[4]  = mk(0, 2,  0, 1, 0,  0, 2,  1, LAT_IMM);
    vecs[5]  = mk(0, 80, 0, 0, 0,  0, 2,  1, LAT_IMM);
    vecs[6]  = mk(0, 79, 0, 1, 77, 1, 79, 1, LAT_DN);
    vecs[7]  = mk(1, 0,  0, 1, 79, 0, 0,  1, LAT_DN);
    vecs[8]  = mk(1, 0,  0, 1, 0,  0, 0,  1, LAT_AT0);
    vecs[9]  = mk(0, 2,  0, 1, 2,  1, 2,  1, LAT_DN);
    vecs[10] = mk(0, 0,  1, 0, 2,  0, 0,  0, LAT_ER);
    vecs[11] = mk(1, 0,  1, 0, 85, 0, -1, 0, LAT_ER);
    vecs[12] = mk(0, 3,  0, 0, 0,  0, -1, 0, LAT_IMM);
    vecs[13] = mk(1, 0,  0, 1, 0,  0, 0,  1, LAT_AT0);

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_recal = 1'b0; cmd_track = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_step", int'(step), 0);
    chk("rst_dir", int'(dir_sel), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_error", int'(error), 0);
    chk("rst_cur", int'(cur_track), 0);
    chk("rst_valid", int'(track_valid), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      cur_id = i;
      run_vec(vecs[i]);
    end

    // Reset in the middle of a step pulse.
    cur_id = 100;
    issue(1'b0, 40);
    for (int i = 0; i < 100 && step !== 1'b1; i++) @(negedge clk);
    chk("mid_step_seen", int'(step), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_step", int'(step), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_valid", int'(track_valid), 0);
    chk("midrst_cur", int'(cur_track), 0);
    chk("midrst_dir", int'(dir_sel), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Head moved one track inward before the reset; recal walks it back.
    cur_id = 101;
    run_vec(mk(1, 0, 0, 1, 1, 0, 0, 1, LAT_DN));

    // Command held high while busy must be neither accepted nor acknowledged.
    cur_id = 102;
    sb.push_back(mk(0, 3, 0, 1, 3, 1, 3, 1, LAT_DN));
    issue(1'b0, 3);
    @(negedge clk);
    cmd_recal = 1'b1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("hold_ready", int'(cmd_ready), 0);
      chk("hold_busy", int'(busy), 1);
    end
    cmd_valid = 1'b0;
    wait_result();
    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/floppy_seek_ctrl.md
Name: floppy_seek_ctrl

Overview:
Host-side initiator for the floppy drive's step/direction interface. It drives dir_sel and step pulses to move the head to a commanded track, and recalibrates to track 0 using the t00_sens input. It sits in the controller FPGA between the command decoder and the drive connector (pins 18/20), and tracks the current head position.

Parameters:
STEP_PULSE_CYC, 4, clk cycles step is held high per pulse (>=1)
STEP_RATE_CYC, 20, clk cycles between rising edges of consecutive steps (> STEP_PULSE_CYC)
DIR_SETUP_CYC, 2, clk cycles dir_sel is stable before the first step edge
SETTLE_CYC, 10, head-settle cycles after the last step, before done
MAX_TRACK, 79, highest legal track number
MAX_RECAL, 85, step budget for recalibrate before error
TRACK_W, 7, track number width

Ports:
clk  in  1  system clock (PLL output)
rst_n  in  1  synchronous, active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
cmd_recal  in  1  1 = recalibrate to track 0, 0 = seek to cmd_track
cmd_track  in  TRACK_W  target track for a seek
dir_sel  out  1  1 = step inward (track+1), 0 = outward (track-1)
step  out  1  active-high step pulse to the drive
t00_sens  in  1  async; high when the head is at track 0
busy  out  1  high from accept until done/error
done  out  1  one-cycle pulse on successful completion
error  out  1  one-cycle pulse on failed command
cur_track  out  TRACK_W  current head track (valid only if track_valid)
track_valid  out  1  position known (set by a successful recal)

Behaviour:
- Reset (rst_n low at clk edge): state IDLE; step=0, dir_sel=0, busy=0, done=0, error=0, cur_track=0, track_valid=0, all counters 0. A mid-operation reset drops step on the same edge; position is lost.
- t00_sens passes through a 2-flop synchroniser; all decisions use the synchronised value (t00_s).
- States: IDLE, DIR_SETUP, STEP_HI, STEP_LO, SETTLE.
- IDLE: cmd_ready=1. On accept:
  - Seek with track_valid=0 or cmd_track>MAX_TRACK: error pulse next cycle; stay IDLE; no pins change.
  - Seek with cmd_track==cur_track: done pulse next cycle; no step.
  - Otherwise latch the target and remaining=|delta|. dir_sel is set on the accept edge (recal: dir_sel=0). busy=1. Go to DIR_SETUP.
- DIR_SETUP: hold for DIR_SETUP_CYC cycles.
  - Recal only: if t00_s=1 at the end, finish without stepping (cur_track=0, track_valid=1, go to SETTLE).
  - Else go to STEP_HI.
- STEP_HI: step=1 for STEP_PULSE_CYC cycles. On entry, cur_track is updated ±1 (recal: step counter +1). Then go to STEP_LO.
- STEP_LO: step=0 for STEP_RATE_CYC−STEP_PULSE_CYC cycles. At the end:
  - Seek: remaining==0 -> SETTLE, else STEP_HI.
  - Recal: t00_s=1 -> cur_track=0, track_valid=1, SETTLE.
  - Recal: step count==MAX_RECAL -> error pulse, track_valid=0, IDLE.
  - Recal: otherwise STEP_HI.
- SETTLE: SETTLE_CYC cycles, then done pulse and IDLE. busy drops in the same cycle done is high.
- Seek outward reaching cur_track 0 with t00_s=0 at the end of the last STEP_LO: error pulse, track_valid=0.
- cur_track arithmetic is TRACK_W unsigned. It never goes below 0 or above MAX_TRACK, because targets are range-checked.
- dir_sel changes only in IDLE/accept, never while step=1.
- cmd_* inputs are ignored when not in IDLE; there is no queueing.

Decomposition:
- Package floppy_pkg: state enum, TRACK_W, MAX_TRACK, and direction constants DIR_IN=1, DIR_OUT=0.
- One sub-module, floppy_step_timer: loadable down-counter with a zero flag, reused for the setup, pulse, rate and settle intervals.

Test Plan:
- Recal from reset: t00_sens rises after the 3rd step -> exactly 3 step pulses, each 4 cycles high on a 20-cycle period, dir_sel=0, then done, cur_track=0, track_valid=1.
- Seek 0->5: 5 pulses with dir_sel=1. First step rise occurs 2 cycles after accept+1. done arrives 10 cycles after the last STEP_LO ends. cur_track=5.
- Seek 5->2: dir_sel=0, 3 pulses, cur_track=2. Seek 2->2: done one cycle after accept, no step.
- Errors: seek before any recal -> error pulse, no step. Seek to 80 -> error. Recal with t00_sens stuck low -> 85 pulses then error, track_valid=0.
- rst_n low while step=1 mid-seek -> step=0 on the next edge, busy=0, track_valid=0. cmd_valid held during busy -> not accepted, cmd_ready=0.
- Protocol check across all tests: dir_sel never toggles while step=1, and step high width and period always equal the parameters.
